dotp_sequencer: RTL and testbench
=================================

Name: dotp_sequencer

Overview:
Job sequencer for the dot-product accelerator. A single `start` triggers one job: fetch A[i] and B[i] through a shared memory read port, feed each pair to the external MAC, then write the final accumulator to the output address. It sits between the AXI-Lite register front end (job config, start, status) and the read/write master channels plus the MAC datapath, and owns all phase ordering.

Parameters:
LEN_W, 16, width of vector length and element counter
TIMEOUT_CYC, 256, max cycles waiting for any response before abort; 0 disables the timeout
ADDR_STEP, 4, byte increment per element

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  job start pulse; sampled only in IDLE
addr_a  in  32  base byte address of vector A
addr_b  in  32  base byte address of vector B
addr_out  in  32  result byte address
vec_len  in  LEN_W  element count
busy  out  1  high from start acceptance until DONE exits
done  out  1  one-cycle pulse at job end
status_err  out  1  sticky error flag; cleared on next accepted start
elem_cnt  out  LEN_W  elements completed in current job
rd_req_valid  out  1  read request valid
rd_req_addr  out  32  read address
rd_req_ready  in  1  read request accepted
rd_rsp_valid  in  1  read data valid
rd_rsp_data  in  32  read data
rd_rsp_err  in  1  read error (qualified by rd_rsp_valid)
wr_req_valid  out  1  write request valid
wr_req_addr  out  32  write address
wr_req_data  out  32  write data
wr_req_ready  in  1  write request accepted
wr_rsp_valid  in  1  write response valid
wr_rsp_err  in  1  write error (qualified by wr_rsp_valid)
mac_clear  out  1  one-cycle accumulator clear
mac_en  out  1  one-cycle MAC enable
mac_a  out  32  operand A
mac_b  out  32  operand B
mac_acc  in  32  MAC accumulator; valid 1 cycle after mac_en

Behaviour:
- Reset (rst=1 at posedge) takes effect in the same edge: state IDLE. All outputs go to 0, including valids, strobes, operands, addresses, busy, done, status_err and elem_cnt. Reset mid-job aborts with no done pulse and no outstanding-request tracking.
- States: IDLE, RD_A, WT_A, RD_B, WT_B, MAC, DRAIN, WR, WT_WR, DONE.
- IDLE:
  - On start, latch addr_a, addr_b, addr_out and vec_len into config registers.
  - Clear status_err and elem_cnt; pulse mac_clear; set busy.
  - Go to RD_A, or to DRAIN if vec_len==0.
- RD_A/RD_B:
  - Assert rd_req_valid with ptr_a/ptr_b.
  - Address and valid stay stable until rd_req_ready; the handshake completes on the cycle both are high.
  - Then go to WT_A/WT_B.
- WT_A/WT_B:
  - On rd_rsp_valid, capture rd_rsp_data into mac_a/mac_b.
  - Advance the pointer by ADDR_STEP (mod 2^32, wraps silently).
  - WT_A goes to RD_B. WT_B goes to MAC.
- MAC:
  - Pulse mac_en for 1 cycle and increment elem_cnt.
  - If elem_cnt+1 == vec_len, go to DRAIN; else go to RD_A.
- DRAIN: wait exactly 1 cycle for mac_acc to settle, then go to WR.
- WR:
  - wr_req_valid=1, wr_req_addr=addr_out, wr_req_data=mac_acc sampled on DRAIN exit and held.
  - On wr_req_ready, go to WT_WR.
- WT_WR: on wr_rsp_valid, go to DONE.
- DONE: pulse done, drop busy the following cycle, go to IDLE.
- Error/timeout:
  - rd_rsp_err or wr_rsp_err with its valid sets status_err; go to DONE with no further requests and no MAC pulse for that element.
  - A cycle counter runs in WT_A, WT_B and WT_WR and resets on state entry. Reaching TIMEOUT_CYC sets status_err and goes to DONE.
- start while busy is ignored. Config inputs are sampled only at acceptance.
- Only one outstanding request per channel. Responses arriving outside WT_* are ignored.
- vec_len==0: writes the cleared accumulator (0), done asserted, elem_cnt=0.
- Latency for N elements with zero-wait memory (ready same cycle, response next cycle): 1 (IDLE) + 5N + 1 (DRAIN) + 2 (WR, WT_WR) + 1 (DONE).

Decomposition:
- Shared package dotp_pkg holds:
  - the state enum;
  - LEN_W default;
  - ADDR_STEP;
  - the status bit positions used by the AXI-Lite register file (busy=0, done=1, err=2).
- One natural sub-module, dotp_timeout_cnt: counter with clear, enable and TIMEOUT_CYC compare, reused by the host-side status logic.

Test Plan:
1. Basic job:
   - Stimulus: addr_a=0x10, addr_b=0x20, addr_out=0x30, vec_len=4. Memory A={1,2,3,4}, B={5,6,7,8}; testbench MAC model.
   - Required response: read addresses in order 0x10, 0x20, 0x14, 0x24, ...; 4 mac_en pulses; write 0x30 ← 70; done=1, status_err=0, elem_cnt=4.
2. Backpressure:
   - Stimulus: rd_req_ready low for 3 cycles per request, and responses delayed 5 cycles.
   - Required response: address stays stable while waiting; result unchanged (70); no duplicate requests.
3. Zero length:
   - Stimulus: vec_len=0.
   - Required response: no read requests; one mac_clear; write 0x30 ← 0; done pulse.
4. Read error:
   - Stimulus: rd_rsp_err on the B[1] response.
   - Required response: status_err=1; done pulse; no wr_req_valid; elem_cnt=1.
5. Timeout:
   - Stimulus: TIMEOUT_CYC=8, rd_rsp_valid never returned.
   - Required response: done exactly 8 cycles after WT_A entry; status_err=1.
6. Reset and restart:
   - Stimulus: rst mid-job during WT_B; start re-pulsed during busy.
   - Required response: after reset, all outputs are 0 and the block is in IDLE; a second start while busy is ignored; the next start after IDLE runs a clean job.

Source files
------------

// File: rtl/dotp_pkg.sv
// Shared types and constants for the dot-product job sequencer and its host-side status logic.
package dotp_pkg;

    localparam int          DOTP_LEN_W       = 16;
    localparam int unsigned DOTP_ADDR_STEP   = 4;
    localparam int unsigned DOTP_TIMEOUT_CYC = 256;

    // Bit positions of the status word exposed by the AXI-Lite register file.
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_A,
        S_WT_A,
        S_RD_B,
        S_WT_B,
        S_MAC,
        S_DRAIN,
        S_WR,
        S_WT_WR,
        S_DONE
    } state_t;

    function automatic logic is_wait_state(input state_t s);
        return (s == S_WT_A) || (s == S_WT_B) || (s == S_WT_WR);
    endfunction

endpackage

// File: rtl/dotp_sequencer_if.sv
// Read and write request/response channels between the job sequencer and the memory masters.
interface dotp_sequencer_if;

    logic        rd_req_valid;
    logic [31:0] rd_req_addr;
    logic        rd_req_ready;
    logic        rd_rsp_valid;
    logic [31:0] rd_rsp_data;
    logic        rd_rsp_err;

    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic [31:0] wr_req_data;
    logic        wr_req_ready;
    logic        wr_rsp_valid;
    logic        wr_rsp_err;

    modport master (
        output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
        input  wr_req_ready, wr_rsp_valid, wr_rsp_err
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data, rd_rsp_err,
        output wr_req_ready, wr_rsp_valid, wr_rsp_err
    );

endinterface

// File: rtl/dotp_timeout_cnt.sv
// Wait-cycle counter: cleared on demand, counts while enabled, flags the last allowed cycle.
module dotp_timeout_cnt #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A limit of zero disables the timeout entirely.
    assign expired = (LIMIT != 0) && en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/dotp_sequencer.sv
// Dot-product job sequencer: fetches A/B element pairs, drives the external MAC, writes the result.
module dotp_sequencer
    import dotp_pkg::*;
#(
    parameter int          LEN_W       = DOTP_LEN_W,
    parameter int unsigned TIMEOUT_CYC = DOTP_TIMEOUT_CYC,
    parameter int unsigned ADDR_STEP   = DOTP_ADDR_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      addr_a,
    input  logic [31:0]      addr_b,
    input  logic [31:0]      addr_out,
    input  logic [LEN_W-1:0] vec_len,
    output logic             busy,
    output logic             done,
    output logic             status_err,
    output logic [LEN_W-1:0] elem_cnt,
    dotp_sequencer_if.master mem,
    output logic             mac_clear,
    output logic             mac_en,
    output logic [31:0]      mac_a,
    output logic [31:0]      mac_b,
    input  logic [31:0]      mac_acc
);

    state_t           state;
    logic [31:0]      ptr_a;
    logic [31:0]      ptr_b;
    logic [31:0]      cfg_out;
    logic [LEN_W-1:0] cfg_len;
    logic [LEN_W-1:0] elem_next;

    logic             rd_req_valid_q;
    logic [31:0]      rd_req_addr_q;
    logic             wr_req_valid_q;
    logic [31:0]      wr_req_addr_q;
    logic [31:0]      wr_req_data_q;

    logic             timed_out;
    logic             rsp_ok;
    logic             abort;

    assign mem.rd_req_valid = rd_req_valid_q;
    assign mem.rd_req_addr  = rd_req_addr_q;
    assign mem.wr_req_valid = wr_req_valid_q;
    assign mem.wr_req_addr  = wr_req_addr_q;
    assign mem.wr_req_data  = wr_req_data_q;

    assign elem_next = elem_cnt + LEN_W'(1);

    dotp_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!is_wait_state(state)),
        .en      (is_wait_state(state)),
        .expired (timed_out)
    );

    // A wait state ends either with a clean response or an abort (error response or timeout).
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
        rsp_ok = 1'b0;
        abort  = 1'b0;
        unique case (state)
            S_WT_A, S_WT_B: begin
                rsp_ok = mem.rd_rsp_valid && !mem.rd_rsp_err;
                abort  = mem.rd_rsp_valid ? mem.rd_rsp_err : timed_out;
            end
            S_WT_WR: begin
                rsp_ok = mem.wr_rsp_valid && !mem.wr_rsp_err;
                abort  = mem.wr_rsp_valid ? mem.wr_rsp_err : timed_out;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ptr_a          <= '0;
            ptr_b          <= '0;
            cfg_out        <= '0;
            cfg_len        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            status_err     <= 1'b0;
            elem_cnt       <= '0;
            rd_req_valid_q <= 1'b0;
            rd_req_addr_q  <= '0;
            wr_req_valid_q <= 1'b0;
            wr_req_addr_q  <= '0;
            wr_req_data_q  <= '0;
            mac_clear      <= 1'b0;
            mac_en         <= 1'b0;
            mac_a          <= '0;
            mac_b          <= '0;
        end else begin
            mac_clear <= 1'b0;
            mac_en    <= 1'b0;
            done      <= 1'b0;

            if (abort) begin
                status_err <= 1'b1;
                done       <= 1'b1;
                state      <= S_DONE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            ptr_a      <= addr_a;
                            ptr_b      <= addr_b;
                            cfg_out    <= addr_out;
                            cfg_len    <= vec_len;
                            status_err <= 1'b0;
                            elem_cnt   <= '0;
                            mac_clear  <= 1'b1;
                            busy       <= 1'b1;
                            if (vec_len == '0) begin
                                state <= S_DRAIN;
                            end else begin
                                rd_req_valid_q <= 1'b1;
                                rd_req_addr_q  <= addr_a;
                                state          <= S_RD_A;
                            end
                        end
                    end
                    S_RD_A, S_RD_B: begin
                        if (mem.rd_req_ready) begin
                            rd_req_valid_q <= 1'b0;
                            state          <= (state == S_RD_A) ? S_WT_A : S_WT_B;
                        end
                    end
                    S_WT_A: begin
                        if (rsp_ok) begin
                            mac_a          <= mem.rd_rsp_data;
                            ptr_a          <= ptr_a + 32'(ADDR_STEP);
                            rd_req_valid_q <= 1'b1;
                            rd_req_addr_q  <= ptr_b;
                            state          <= S_RD_B;
                        end
                    end
                    S_WT_B: begin
                        if (rsp_ok) begin
                            mac_b  <= mem.rd_rsp_data;
                            ptr_b  <= ptr_b + 32'(ADDR_STEP);
                            mac_en <= 1'b1;
                            state  <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        elem_cnt <= elem_next;
                        if (elem_next == cfg_len) begin
                            state <= S_DRAIN;
                        end else begin
                            rd_req_valid_q <= 1'b1;
                            rd_req_addr_q  <= ptr_a;
                            state          <= S_RD_A;
                        end
                    end
                    S_DRAIN: begin
                        // The clear pulse of an empty job has not reached mac_acc yet.
                        wr_req_valid_q <= 1'b1;
                        wr_req_addr_q  <= cfg_out;
                        wr_req_data_q  <= (cfg_len == '0) ? '0 : mac_acc;
                        state          <= S_WR;
                    end
                    S_WR: begin
                        if (mem.wr_req_ready) begin
                            wr_req_valid_q <= 1'b0;
                            state          <= S_WT_WR;
                        end
                    end
                    S_WT_WR: begin
                        if (rsp_ok) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dotp_sequencer.sv
// Directed bench for dotp_sequencer: memory slave and MAC models, hand-computed expectations.
module tb_dotp_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic [31:0] addr_out;
    logic [15:0] vec_len;
    logic        busy;
    logic        done;
    logic        status_err;
    logic [15:0] elem_cnt;
    logic        mac_clear;
    logic        mac_en;
    logic [31:0] mac_a;
    logic [31:0] mac_b;
    logic [31:0] acc_model = '0;

    dotp_sequencer_if bus ();

    dotp_sequencer #(
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .addr_out   (addr_out),
        .vec_len    (vec_len),
        .busy       (busy),
        .done       (done),
        .status_err (status_err),
        .elem_cnt   (elem_cnt),
        .mem        (bus),
        .mac_clear  (mac_clear),
        .mac_en     (mac_en),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_acc    (acc_model)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Accumulator of the external MAC: result visible one cycle after mac_en.
    always @(posedge clk) begin
        if (mac_clear)   acc_model <= '0;
        else if (mac_en) acc_model <= acc_model + mac_a * mac_b;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Slave behaviour knobs, written only by the main sequence.
    int ready_wait = 0;
    int rsp_delay  = 0;
    int err_at     = -1;
    bit rd_drop    = 1'b0;

    // Observations, written only by the slave/monitor process.
    logic [31:0] mem [64];
    logic [31:0] rd_log [$];
    int          rd_total = 0, wr_total = 0, mac_en_total = 0, mac_clr_total = 0;
    int          done_total = 0, unstable = 0, hs_cyc = 0;
    logic [31:0] wr_addr_last = '0, wr_data_last = '0;

    initial begin
        bit          rd_pend = 0, rd_wait = 0, wr_pend = 0, wr_wait = 0, rd_err_q = 0;
        int          rd_left = 0, rd_dly = 0, wr_left = 0;
        logic [31:0] rd_data_q = '0, rd_prev_addr = '0;
        bus.rd_req_ready = 1'b0; bus.rd_rsp_valid = 1'b0; bus.rd_rsp_data = '0; bus.rd_rsp_err = 1'b0;
        bus.wr_req_ready = 1'b0; bus.wr_rsp_valid = 1'b0; bus.wr_rsp_err = 1'b0;
        forever begin
            @(negedge clk);
            bus.rd_req_ready = 1'b0; bus.rd_rsp_valid = 1'b0; bus.rd_rsp_data = '0; bus.rd_rsp_err = 1'b0;
            bus.wr_req_ready = 1'b0; bus.wr_rsp_valid = 1'b0; bus.wr_rsp_err = 1'b0;
            if (mac_en)    mac_en_total++;
            if (mac_clear) mac_clr_total++;
            if (done)      done_total++;
            if (rst) begin
                rd_pend = 0; rd_wait = 0; wr_pend = 0; wr_wait = 0;
            end else begin
                if (rd_pend) begin
                    if (rd_dly == 0) begin
                        bus.rd_rsp_valid = 1'b1;
                        bus.rd_rsp_data  = rd_data_q;
                        bus.rd_rsp_err   = rd_err_q;
                        rd_pend = 0;
                    end else begin
                        rd_dly--;
                    end
                end else if (bus.rd_req_valid) begin
                    if (rd_wait && bus.rd_req_addr != rd_prev_addr) unstable++;
                    if (!rd_wait) begin
                        rd_wait = 1; rd_left = ready_wait; rd_prev_addr = bus.rd_req_addr;
                    end
                    if (rd_left == 0) begin
                        bus.rd_req_ready = 1'b1;
                        rd_wait   = 0;
                        rd_log.push_back(bus.rd_req_addr);
                        rd_data_q = mem[bus.rd_req_addr[7:2]];
                        rd_err_q  = (rd_total == err_at);
                        rd_total++;
                        hs_cyc    = cyc;
                        rd_pend   = !rd_drop;
                        rd_dly    = rsp_delay;
                    end else begin
                        rd_left--;
                    end
                end else if (rd_wait) begin
                    unstable++;
                    rd_wait = 0;
                end

                if (wr_pend) begin
                    bus.wr_rsp_valid = 1'b1;
                    wr_pend = 0;
                end else if (bus.wr_req_valid) begin
                    if (!wr_wait) begin
                        wr_wait = 1; wr_left = ready_wait;
                    end
                    if (wr_left == 0) begin
                        bus.wr_req_ready = 1'b1;
                        wr_wait      = 0;
                        wr_total++;
                        wr_addr_last = bus.wr_req_addr;
                        wr_data_last = bus.wr_req_data;
                        wr_pend      = 1;
                    end else begin
                        wr_left--;
                    end
                end
            end
        end
    end

    // Latency counts the accept cycle through the DONE cycle inclusive.
    task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] o,
                           input logic [15:0] n, input int restart_at,
                           output int lat, output bit seen, output int dcyc);
        @(negedge clk);
        addr_a = a; addr_b = b; addr_out = o; vec_len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        addr_a = 32'hBAD0_0000; addr_b = 32'hBAD0_0100; addr_out = 32'h0000_0040; vec_len = 16'd1;
        lat = 2; seen = 1'b0; dcyc = 0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
            start = (i == restart_at);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_ctrl"}, {25'd0, busy, done, status_err, mac_clear, mac_en,
                               bus.rd_req_valid, bus.wr_req_valid}, 32'd0);
        check({tag, "_elem_cnt"}, {16'd0, elem_cnt}, 32'd0);
        check({tag, "_rd_addr"}, bus.rd_req_addr, 32'd0);
        check({tag, "_wr_addr"}, bus.wr_req_addr, 32'd0);
        check({tag, "_wr_data"}, bus.wr_req_data, 32'd0);
        check({tag, "_mac_a"}, mac_a, 32'd0);
        check({tag, "_mac_b"}, mac_b, 32'd0);
    endtask

    task automatic check_rd_order(input string tag, input int base);
        logic [31:0] exp;
        check({tag, "_rd_cnt"}, rd_log.size() - base, 8);
        for (int k = 0; k < 8 && base + k < rd_log.size(); k++) begin
            exp = ((k % 2) == 0) ? 32'h10 + 32'(4 * (k / 2)) : 32'h20 + 32'(4 * (k / 2));
            check($sformatf("%s_rd_addr%0d", tag, k), rd_log[base + k], exp);
        end
    endtask

    initial begin
        int lat, dcyc, rd0, wr0, me0, mc0, dn0, un0, lb;
        bit seen, reached;

        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) begin
            mem[4 + i] = 32'(i + 1);   // A at 0x10: 1,2,3,4
            mem[8 + i] = 32'(i + 5);   // B at 0x20: 5,6,7,8
        end
        rst = 1'b1; start = 1'b0;
        addr_a = '0; addr_b = '0; addr_out = '0; vec_len = '0;
        repeat (3) @(negedge clk);
        check_reset_zero("por");
        rst = 1'b0;

        // Basic job: 1*5 + 2*6 + 3*7 + 4*8 = 70
        rd0 = rd_total; wr0 = wr_total; me0 = mac_en_total; mc0 = mac_clr_total; lb = rd_log.size();
        run_job(32'h10, 32'h20, 32'h30, 16'd4, -1, lat, seen, dcyc);
        check("basic_done", {31'd0, seen}, 32'd1);
        check("basic_latency", lat, 25);
        check("basic_err", {31'd0, status_err}, 32'd0);
        check("basic_elem_cnt", {16'd0, elem_cnt}, 32'd4);
        check_rd_order("basic", lb);
        check("basic_mac_en", mac_en_total - me0, 4);
        check("basic_mac_clear", mac_clr_total - mc0, 1);
        check("basic_wr_cnt", wr_total - wr0, 1);
        check("basic_wr_addr", wr_addr_last, 32'h30);
        check("basic_wr_data", wr_data_last, 32'd70);

        // Backpressure on both channels plus slow read responses
        ready_wait = 3; rsp_delay = 5;
        rd0 = rd_total; wr0 = wr_total; un0 = unstable; lb = rd_log.size();
        run_job(32'h10, 32'h20, 32'h30, 16'd4, -1, lat, seen, dcyc);
        ready_wait = 0; rsp_delay = 0;
        check("bp_done", {31'd0, seen}, 32'd1);
        check("bp_addr_stable", unstable - un0, 0);
        check_rd_order("bp", lb);
        check("bp_wr_cnt", wr_total - wr0, 1);
        check("bp_wr_data", wr_data_last, 32'd70);
        check("bp_elem_cnt", {16'd0, elem_cnt}, 32'd4);

        // Zero length: cleared accumulator written even though the MAC still holds 70
        rd0 = rd_total; wr0 = wr_total; me0 = mac_en_total; mc0 = mac_clr_total;
        run_job(32'h10, 32'h20, 32'h30, 16'd0, -1, lat, seen, dcyc);
        check("zero_done", {31'd0, seen}, 32'd1);
        check("zero_latency", lat, 5);
        check("zero_rd_cnt", rd_total - rd0, 0);
        check("zero_mac_clear", mac_clr_total - mc0, 1);
        check("zero_mac_en", mac_en_total - me0, 0);
        check("zero_wr_cnt", wr_total - wr0, 1);
        check("zero_wr_addr", wr_addr_last, 32'h30);
        check("zero_wr_data", wr_data_last, 32'd0);
        check("zero_elem_cnt", {16'd0, elem_cnt}, 32'd0);

        // Read error on the B[1] response (fourth read of the job)
        rd0 = rd_total; wr0 = wr_total; me0 = mac_en_total;
        err_at = rd_total + 3;
        run_job(32'h10, 32'h20, 32'h30, 16'd4, -1, lat, seen, dcyc);
        err_at = -1;
        check("rderr_done", {31'd0, seen}, 32'd1);
        check("rderr_err", {31'd0, status_err}, 32'd1);
        check("rderr_elem_cnt", {16'd0, elem_cnt}, 32'd1);
        check("rderr_rd_cnt", rd_total - rd0, 4);
        check("rderr_mac_en", mac_en_total - me0, 1);
        check("rderr_wr_cnt", wr_total - wr0, 0);

        // Timeout: A[0] request accepted, response never returned
        rd0 = rd_total; wr0 = wr_total; me0 = mac_en_total;
        rd_drop = 1'b1;
        run_job(32'h10, 32'h20, 32'h30, 16'd4, -1, lat, seen, dcyc);
        rd_drop = 1'b0;
        check("tmo_done", {31'd0, seen}, 32'd1);
        check("tmo_err", {31'd0, status_err}, 32'd1);
        check("tmo_cycles_after_wt_a", dcyc - (hs_cyc + 1), 8);
        check("tmo_rd_cnt", rd_total - rd0, 1);
        check("tmo_mac_en", mac_en_total - me0, 0);
        check("tmo_wr_cnt", wr_total - wr0, 0);

        // Reset while waiting for the B[0] response
        rsp_delay = 5;
        rd0 = rd_total;
        @(negedge clk);
        addr_a = 32'h10; addr_b = 32'h20; addr_out = 32'h30; vec_len = 16'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rd_total >= rd0 + 2) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reached_wt_b", {31'd0, reached}, 32'd1);
        repeat (2) @(negedge clk);
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_zero("midrst");
        rst = 1'b0;
        rsp_delay = 0;

        // Second start while busy must be ignored
        wr0 = wr_total; dn0 = done_total;
        run_job(32'h10, 32'h20, 32'h30, 16'd4, 5, lat, seen, dcyc);
        check("restart_done", {31'd0, seen}, 32'd1);
        check("restart_latency", lat, 25);
        check("restart_wr_addr", wr_addr_last, 32'h30);
        check("restart_wr_data", wr_data_last, 32'd70);
        check("restart_elem_cnt", {16'd0, elem_cnt}, 32'd4);
        repeat (10) @(negedge clk);
        check("restart_done_cnt", done_total - dn0, 1);
        check("restart_wr_cnt", wr_total - wr0, 1);
        check("restart_idle", {31'd0, busy}, 32'd0);

        // Clean job from IDLE after the disturbed run
        run_job(32'h10, 32'h20, 32'h30, 16'd4, -1, lat, seen, dcyc);
        check("clean_done", {31'd0, seen}, 32'd1);
        check("clean_err", {31'd0, status_err}, 32'd0);
        check("clean_wr_data", wr_data_last, 32'd70);
        check("clean_elem_cnt", {16'd0, elem_cnt}, 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
